// File: rtl/circle_hit_tester.sv
// Multi-cycle point-in-circle tester: one shared multiplier squares dx then dy, then compares.
// Optional annulus test is enabled by defining CIRCLE_RING_EN.
module circle_hit_tester #(
   parameter int COORD_W   = 10,
   parameter int CX        = 320,
   parameter int CY        = 240,
   parameter int RADIUS_SQ = 10000,
   parameter int INNER_SQ  = 2500,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [COORD_W-1:0]        x,
   input  logic [COORD_W-1:0]        y,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*COORD_W+1:0]      dist_sq,
   output logic                      hit,
   output logic [CNT_W-1:0]          hit_count
);

   localparam int SQ_W = 2*COORD_W+2;

   localparam logic signed [COORD_W:0] CX_S  = (COORD_W+1)'(CX);
   localparam logic signed [COORD_W:0] CY_S  = (COORD_W+1)'(CY);
   localparam logic [SQ_W-1:0]         OUTER = SQ_W'(RADIUS_SQ);

   // Centre coordinates must be representable, squared radii non-negative.
   if (CX < 0 || CX >= 2**COORD_W || CY < 0 || CY >= 2**COORD_W ||
       RADIUS_SQ < 0 || INNER_SQ < 0) begin : g_param_check
      $error("circle_hit_tester: illegal parameter value");
   end

   typedef enum logic [2:0] {IDLE, SQX, SQY, CMP, DONE} state_t;

   state_t state, state_nxt;

   logic signed [COORD_W:0] dx, dy;
   logic signed [COORD_W:0] mul_op;
   logic signed [SQ_W-1:0]  op_ext;
   logic signed [SQ_W-1:0]  prod;
   logic [SQ_W-1:0]         sq;
   logic [SQ_W-1:0]         acc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != {CNT_W{1'b1}}))
         return v + CNT_W'(1);
      return v;
   endfunction

`ifdef CIRCLE_RING_EN
   localparam logic [SQ_W-1:0] INNER = SQ_W'(INNER_SQ);

   function automatic logic in_shape(input logic [SQ_W-1:0] d);
      return (d >= INNER) && (d < OUTER);
   endfunction
`else
   function automatic logic in_shape(input logic [SQ_W-1:0] d);
      return d < OUTER;
   endfunction
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = SQX;
         SQX:     state_nxt = SQY;
         SQY:     state_nxt = CMP;
         CMP:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: only IDLE accepts a sample
   always_comb begin
      in_ready = (state == IDLE);
   end

   // Shared squarer: operand selected by state, sign-extended so the product is exact
   always_comb begin
      mul_op = (state == SQX) ? dx : dy;
      op_ext = SQ_W'(mul_op);
      prod   = op_ext * op_ext;
      sq     = $unsigned(prod);
   end

   // Datapath registers: no reset, they are always loaded before use
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (in_valid) begin
               dx <= $signed({1'b0, x}) - CX_S;
               dy <= $signed({1'b0, y}) - CY_S;
            end
         end
         SQX:     acc <= sq;
         SQY:     acc <= acc + sq;
         default: ;
      endcase
   end

   // Result port and hit counter
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         dist_sq   <= '0;
         hit       <= 1'b0;
         hit_count <= '0;
      end else begin
         case (state)
            CMP: begin
               dist_sq   <= acc;
               hit       <= in_shape(acc);
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  hit_count <= sat_inc(hit_count, hit);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_circle_hit_tester.sv
// Directed self-checking bench for circle_hit_tester (CNT_W=4 to reach counter saturation).
// Build with CIRCLE_RING_EN defined to check the annulus variant.
module tb_circle_hit_tester;

   localparam int CNT_W = 4;
   localparam int SQ_W  = 22;
   localparam int CMAX  = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [9:0]       x, y;
   logic             out_valid;
   logic             out_ready;
   logic [SQ_W-1:0]  dist_sq;
   logic             hit;
   logic [CNT_W-1:0] hit_count;

   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;

   typedef struct {
      int x;
      int y;
      int d;
      bit hit_c;
      bit hit_r;
   } vec_t;

   vec_t vecs[12];

   circle_hit_tester #(
      .COORD_W(10), .CX(320), .CY(240), .RADIUS_SQ(10000), .INNER_SQ(2500), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
      .dist_sq(dist_sq), .hit(hit), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic bit pick(input bit c, input bit r);
`ifdef CIRCLE_RING_EN
      return r;
`else
      return c;
`endif
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_sample(input int sx, input int sy, input int ed, input bit eh);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready before accept", in_ready, 1);
      x = 10'(sx); y = 10'(sy); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check($sformatf("latency (%0d,%0d)", sx, sy), n, 3);
      check($sformatf("dist_sq (%0d,%0d)", sx, sy), dist_sq, ed);
      check($sformatf("hit (%0d,%0d)", sx, sy), hit, eh);
      if (eh && exp_cnt < CMAX) exp_cnt++;
      @(posedge clk); #1;
      check("out_valid after handshake", out_valid, 0);
      check("in_ready after handshake", in_ready, 1);
      check($sformatf("hit_count (%0d,%0d)", sx, sy), hit_count, exp_cnt);
   endtask

   initial begin
      bit stable;
      vecs[0]  = '{320,  240,       0, 1, 0};
      vecs[1]  = '{420,  240,   10000, 0, 0};
      vecs[2]  = '{419,  240,    9801, 1, 1};
      vecs[3]  = '{0,    0,    160000, 0, 0};
      vecs[4]  = '{1023, 1023, 1107298, 0, 0};
      vecs[5]  = '{340,  240,     400, 1, 0};
      vecs[6]  = '{370,  240,    2500, 1, 1};
      vecs[7]  = '{320,  340,   10000, 0, 0};
      vecs[8]  = '{320,  140,   10000, 0, 0};
      vecs[9]  = '{320,  141,    9801, 1, 1};
      vecs[10] = '{250,  200,    6500, 1, 1};
      vecs[11] = '{260,  180,    7200, 1, 1};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset dist_sq", dist_sq, 0);
      check("reset hit", hit, 0);
      check("reset hit_count", hit_count, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("in_ready after reset", in_ready, 1);

      for (int i = 0; i < 12; i++)
         run_sample(vecs[i].x, vecs[i].y, vecs[i].d, pick(vecs[i].hit_c, vecs[i].hit_r));

      // Output stall: result must hold and new samples must be refused
      out_ready = 1'b0;
      x = 10'd380; y = 10'd290; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 0; n < 20 && !out_valid; n++) begin
         @(posedge clk); #1;
      end
      check("stall out_valid rise", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         x = 10'(i * 50); y = 10'(i * 20);
         @(posedge clk); #1;
         check("stall out_valid", out_valid, 1);
         check("stall dist_sq", dist_sq, 6100);
         check("stall hit", hit, 1);
         check("stall in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (exp_cnt < CMAX) exp_cnt++;
      @(posedge clk); #1;
      check("stall release out_valid", out_valid, 0);
      check("stall release in_ready", in_ready, 1);
      check("stall release hit_count", hit_count, exp_cnt);

      // Reset while the sample sits in SQY
      x = 10'd320; y = 10'd240; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_cnt = 0;
      check("midreset out_valid", out_valid, 0);
      check("midreset in_ready", in_ready, 1);
      check("midreset hit_count", hit_count, 0);
      check("midreset dist_sq", dist_sq, 0);
      check("midreset hit", hit, 0);
      stable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid) stable = 1'b0;
      end
      check("midreset no result", stable, 1);

      // Counter saturation: 20 hits into a 4-bit counter
      for (int i = 0; i < 20; i++)
         run_sample(370, 270, 3400, 1'b1);
      check("saturated hit_count", hit_count, CMAX);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
